// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg: access-size encodings, FSM states and alignment helper for the LSU.
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RMW_WR   = 2'd2,
    RESP_ERR = 2'd3
  } lsu_state_t;

  // Reserved size is treated as a misalignment so one check covers both.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align: load lane extract/extend and sub-word store merge (combinational).
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] load_data,
  output logic [31:0] merged_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(rdata >> {offset, 3'b000});
  assign w_half = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{sign & w_byte[7]}}, w_byte};
      SZ_HALF: load_data = {{16{sign & w_half[15]}}, w_half};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged_data = rdata;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0:    merged_data[7:0]   = wdata[7:0];
          2'd1:    merged_data[15:8]  = wdata[7:0];
          2'd2:    merged_data[23:16] = wdata[7:0];
          default: merged_data[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged_data[31:16] = wdata[15:0];
        else           merged_data[15:0]  = wdata[15:0];
      end
      default: merged_data = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit: byte/half/word load-store front end for word-indexed data_memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] c_ram_words = 30'(RAM_SIZE);

  lsu_state_t  r_state;
  lsu_state_t  w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept    = (r_state == IDLE) && req_valid;
  assign w_req_err   = misaligned(req_size, req_addr[1:0]) || (req_addr[31:2] >= c_ram_words);
  assign mem_address = {2'b00, r_addr[31:2]};

  lsu_align u_align (
    .rdata       (mem_rdata),
    .wdata       (r_wdata),
    .offset      (r_addr[1:0]),
    .size        (r_size),
    .sign        (r_signed),
    .load_data   (w_load),
    .merged_data (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Strobes depend on the state register only, so reset removes them at once.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = r_wdata;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? RESP_ERR : ACCESS;
      end
      ACCESS: begin
        if (r_write && (r_size == SZ_WORD)) begin
          mem_write = 1'b1;
          w_next    = IDLE;
        end else if (r_write) begin
          mem_read = 1'b1;
          w_next   = RMW_WR;
        end else begin
          mem_read = 1'b1;
          w_next   = IDLE;
        end
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = r_merged;
        w_next    = IDLE;
      end
      RESP_ERR: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write    <= 1'b0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merged   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      case (r_state)
        ACCESS: begin
          if (!r_write) begin
            resp_valid <= 1'b1;
            resp_rdata <= w_load;
            resp_err   <= 1'b0;
          end else if (r_size == SZ_WORD) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end else begin
            r_merged <= w_merged;
          end
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        RESP_ERR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit: directed self-checking bench with a behavioural data_memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  int          total = 0;
  int          bad   = 0;
  int          lat;
  logic [7:0]  rdm;
  logic [7:0]  wrm;
  logic [31:0] wdat;

  load_store_unit #(.RAM_SIZE(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && (mem_address < 32'd256)) mem[mem_address[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge, then records per-cycle strobes until resp_valid.
  task automatic xact(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hxxxx_xxxx;
    req_wdata = 32'hxxxx_xxxx;
    lat  = 0;
    rdm  = '0;
    wrm  = '0;
    wdat = '0;
    for (int k = 1; k <= 7 && lat == 0; k++) begin
      @(negedge clk);
      rdm[k] = mem_read;
      wrm[k] = mem_write;
      if (mem_write) wdat = mem_wdata;
      if (resp_valid) lat = k;
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] exp);
    xact(1'b0, sz, sg, a, 32'h0);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_strobes"}, {16'h0, rdm, wrm}, {16'h0, 8'b0000_0010, 8'h00});
  endtask

  task automatic err_chk(input string tag, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a);
    xact(wr, sz, 1'b0, a, 32'h1234_5678);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, 32'(resp_err), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_strobes"}, {16'h0, rdm, wrm}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Word stores: single write cycle, ack two cycles after acceptance.
    xact(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h8081_7F22);
    chk("sw3_lat", 32'(lat), 32'd2);
    chk("sw3_strobes", {16'h0, rdm, wrm}, {16'h0, 8'h00, 8'b0000_0010});
    chk("sw3_wdata", wdat, 32'h8081_7F22);
    chk("sw3_err", 32'(resp_err), 32'd0);
    xact(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h1122_3344);
    chk("sw5_mem", mem[5], 32'h1122_3344);

    load_chk("lb_0E", 2'b00, 1'b1, 32'h0000_000E, 32'hFFFF_FF81);
    load_chk("lbu_0F", 2'b00, 1'b0, 32'h0000_000F, 32'h0000_0080);
    load_chk("lhu_0C", 2'b01, 1'b0, 32'h0000_000C, 32'h0000_7F22);
    load_chk("lh_0E", 2'b01, 1'b1, 32'h0000_000E, 32'hFFFF_8081);
    load_chk("lb_0D", 2'b00, 1'b1, 32'h0000_000D, 32'h0000_007F);

    // Byte store: read in cycle 1, merged write in cycle 2, ack in cycle 3.
    xact(1'b1, 2'b00, 1'b0, 32'h0000_0015, 32'hFFFF_FFAB);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_strobes", {16'h0, rdm, wrm}, {16'h0, 8'b0000_0010, 8'b0000_0100});
    chk("sb_wdata", wdat, 32'h1122_AB44);
    chk("sb_rdata", resp_rdata, 32'h0);
    load_chk("lw_14", 2'b10, 1'b0, 32'h0000_0014, 32'h1122_AB44);

    xact(1'b1, 2'b01, 1'b0, 32'h0000_000E, 32'h0000_BEEF);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_wdata", wdat, 32'hBEEF_7F22);

    xact(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);
    chk("sw20_lat", 32'(lat), 32'd2);
    chk("sw20_strobes", {16'h0, rdm, wrm}, {16'h0, 8'h00, 8'b0000_0010});
    load_chk("lw_20", 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);

    err_chk("e_lh21", 1'b0, 2'b01, 32'h0000_0021);
    err_chk("e_sw22", 1'b1, 2'b10, 32'h0000_0022);
    err_chk("e_rsvd", 1'b0, 2'b11, 32'h0000_0010);
    err_chk("e_range", 1'b0, 2'b10, 32'h0000_0400);
    chk("e_sw22_nowrite", mem[8], 32'hDEAD_BEEF);

    // Last in-range word.
    xact(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D);
    load_chk("lw_3FC", 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D);

    // Back-to-back: second request held on req_valid is accepted in the ack cycle.
    req_write = 1'b1;
    req_size  = 2'b00;
    req_signed = 1'b0;
    req_addr  = 32'h0000_0016;
    req_wdata = 32'h0000_005A;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h0000_0014;
    @(negedge clk);
    chk("bb_c1", {30'h0, req_ready, resp_valid}, 32'b00);
    @(negedge clk);
    chk("bb_c2", {30'h0, req_ready, resp_valid}, 32'b00);
    @(negedge clk);
    chk("bb_c3", {30'h0, req_ready, resp_valid}, 32'b11);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bb_c4", {30'h0, req_ready, resp_valid}, 32'b00);
    chk("bb_c4_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("bb_c5_valid", 32'(resp_valid), 32'd1);
    chk("bb_c5_rdata", resp_rdata, 32'h115A_AB44);

    // Asynchronous reset in the middle of a read-modify-write.
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h0000_0014;
    req_wdata = 32'h0000_0077;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_c1_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    chk("rmw_c2_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("arst_resp", {31'h0, resp_valid} | {31'h0, resp_err}, 32'h0);
    chk("arst_rdata", resp_rdata, 32'h0);
    chk("arst_address", mem_address, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_mem_word", mem[5], 32'h115A_AB44);
    load_chk("lw_after_rst", 2'b10, 1'b0, 32'h0000_0014, 32'h115A_AB44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
